bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumes the 16-bit packed 4-digit BCD count and drives the Basys 3 four-digit multiplexed 7-segment display.
- Scans one digit per refresh tick.
- Snapshots the input once per frame so all four digits in a frame show the same value.
- Decodes BCD to segments, blanks leading zeros, and shows a dash for any non-BCD nibble.

Parameters:
- REFRESH_DIV, 100000: sclk cycles per digit slot (1 kHz per digit at 100 MHz). Legal range is ≥2.
- BLANK_LEADING, 1: 1 blanks leading zero digits 3..1; 0 shows all digits.
- ACTIVE_LOW, 1: 1 makes an/seg/dp active-low (Basys 3); 0 makes them active-high.

Ports:
- sclk  input  1  clock. All state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- bcdcount  input  16  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- dp_en  input  4  decimal point request per digit. Bit i maps to digit i.
- an  output  4  digit anodes. an[i] enables digit i (an[0] is the rightmost).
- seg  output  7  segments {g,f,e,d,c,b,a} as seg[6:0].
- dp  output  1  decimal point segment.
- bad_digit  output  1  sticky flag, set when a snapshotted nibble is greater than 9.

Behaviour:
- Reset (async, rst=1):
  - Prescaler cnt=0, digit index idx=0, shadow=16'h0000, bad_digit=0.
  - All outputs inactive: an=4'b1111, seg=7'b1111111, dp=1 when ACTIVE_LOW=1; inverted when ACTIVE_LOW=0.
  - Mid-scan reset aborts immediately; there is no partial-frame carry-over.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 in the cycle where cnt==REFRESH_DIV-1.
- Digit index:
  - On tick, idx advances 0→1→2→3→0.
  - A frame is REFRESH_DIV*4 cycles.
- Snapshot:
  - On a tick with idx==3 (frame wrap to 0), shadow<=bcdcount and dp_shadow<=dp_en in the same edge.
  - The input is sampled only at that edge. Changes between snapshots are ignored.
  - The first snapshot occurs at cycle 4*REFRESH_DIV after reset release. Until then, shadow=0, so the display shows "0" on digit 0.
- Decode (from shadow nibble selected by idx), shown here as active-low codes:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - Nibble A–F: dash 0111111.
- Blanking (BLANK_LEADING=1):
  - Digit k (k=3..1) is blank when its nibble and all higher nibbles are 0.
  - Digit 0 is never blank.
  - A blank digit drives its anode inactive, all segments off, and dp off, even if dp_en is set.
  - Nonzero invalid nibbles are not zero, so they are never blanked.
- Outputs:
  - Registered. an/seg/dp reflect the idx/shadow values present one cycle earlier (1-cycle latency after idx or shadow changes).
  - Exactly one anode is active per cycle, unless that digit is blanked, in which case none is.
  - When ACTIVE_LOW=0, an/seg/dp are the bitwise inverse of the active-low encoding.
- bad_digit:
  - Set on the snapshot edge if any shadow-loaded nibble is greater than 9.
  - Held until rst. There is no other clear.
- Wrap-around:
  - An input of 9999→0000 is handled by the next snapshot.
  - With BLANK_LEADING=1, the value 0000 shows only "0" on digit 0.

Test Plan:
1. Reset: REFRESH_DIV=4, rst=1 mid-frame → same cycle an=1111, seg=1111111, dp=1, bad_digit=0. After release, first active output is an=1110, seg=1000000 within 2 cycles.
2. Scan/snapshot: bcdcount=16'h1234 held → after the first frame wrap plus 1 cycle, four consecutive 4-cycle slots show an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001. Then repeats.
3. Tearing: change bcdcount from 16'h1234 to 16'h5678 while idx=1 → remaining slots of that frame still show 3,2,1. The next frame shows 8,7,6,5.
4. Blanking: bcdcount=16'h0042, BLANK_LEADING=1 → digits 2 and 3 slots have an=1111. Set BLANK_LEADING=0 → digits 2 and 3 show seg=1000000.
5. Invalid nibble: bcdcount=16'h00A5 → digit 1 shows dash 0111111 (not blanked), digit 0 shows 0010010. bad_digit=1 after the snapshot and stays 1 after bcdcount returns to 16'h0005, until rst.
6. Decimal point: dp_en=4'b0100, bcdcount=16'h0123 → dp=0 only during the digit 2 slot. With bcdcount=16'h0003 (digit 2 blanked), dp stays 1.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// Signal bundle between a BCD count source and the 4-digit 7-segment scanner.
// There is no handshake. bcdcount and dp_en are level inputs that the scanner samples
// only at its frame-wrap edge. an, seg, dp and bad_digit are registered level outputs
// that change only on sclk edges.
interface bcd_display_scanner_if;
  logic [15:0] bcdcount;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        bad_digit;

  modport master (
    output bcdcount, dp_en,
    input  an, seg, dp, bad_digit
  );

  modport slave (
    input  bcdcount, dp_en,
    output an, seg, dp, bad_digit
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Multiplexed 4-digit 7-segment scanner. It snapshots the BCD count once per frame and
// drives one digit per refresh slot, with leading-zero blanking.
module bcd_display_scanner #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                 sclk,
  input  logic                 rst,
  bcd_display_scanner_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    dp_shadow_q, dp_shadow_d;
  logic          bad_q, bad_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, snap, blank;
  logic [3:0]    nib, zero_nib, blank_vec, an_al;
  logic [6:0]    seg_al;
  logic          dp_al;

  // Active-low segment code {g,f,e,d,c,b,a}. Any non-BCD nibble shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  function automatic logic any_gt9(input logic [15:0] v);
    any_gt9 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) any_gt9 = 1'b1;
    end
  endfunction

  always_comb begin
    tick        = (cnt_q == CNT_MAX);
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    snap        = tick && (idx_q == 2'd3);
    shadow_d    = snap ? bus.bcdcount : shadow_q;
    dp_shadow_d = snap ? bus.dp_en : dp_shadow_q;
    bad_d       = bad_q | (snap & any_gt9(bus.bcdcount));

    // A digit is blank when it and every digit above it are zero. Digit 0 always shows.
    for (int i = 0; i < 4; i++) zero_nib[i] = (shadow_q[4*i +: 4] == 4'd0);
    blank_vec[3] = zero_nib[3];
    blank_vec[2] = zero_nib[3] & zero_nib[2];
    blank_vec[1] = zero_nib[3] & zero_nib[2] & zero_nib[1];
    blank_vec[0] = 1'b0;
    blank        = BLANK_LEADING && blank_vec[idx_q];

    nib    = 4'(shadow_q >> {idx_q, 2'b00});
    an_al  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_al = blank ? 7'b1111111 : decode(nib);
    dp_al  = blank ? 1'b1 : ~dp_shadow_q[idx_q];

    // Encoding is built active-low, then flipped once for active-high boards.
    an_d  = an_al ^ {4{~ACTIVE_LOW}};
    seg_d = seg_al ^ {7{~ACTIVE_LOW}};
    dp_d  = dp_al ^ ~ACTIVE_LOW;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      dp_shadow_q <= 4'h0;
      bad_q       <= 1'b0;
      an_q        <= {4{ACTIVE_LOW}};
      seg_q       <= {7{ACTIVE_LOW}};
      dp_q        <= ACTIVE_LOW;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      bad_q       <= bad_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner. Two instances share the stimulus: one blanks leading
// zeros and drives active-low outputs, the other shows all digits and drives active-high.
module tb_bcd_display_scanner;
  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;
  localparam int W     = 26;

  logic        sclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] bcd  = 16'h0000;
  logic [3:0]  dpe  = 4'h0;

  int checks = 0;
  int errors = 0;

  bcd_display_scanner_if if_a ();
  bcd_display_scanner_if if_b ();

  assign if_a.bcdcount = bcd;
  assign if_a.dp_en    = dpe;
  assign if_b.bcdcount = bcd;
  assign if_b.dp_en    = dpe;

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b1)) dut_a (
    .sclk (sclk),
    .rst  (rst),
    .bus  (if_a.slave)
  );

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0), .ACTIVE_LOW(1'b0)) dut_b (
    .sclk (sclk),
    .rst  (rst),
    .bus  (if_b.slave)
  );

  // ---------------- clock ----------------
  always #5 sclk = ~sclk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Returns active-low {an, seg, dp} for the digit shown in a given slot.
  function automatic logic [11:0] ref_view(input int value, input logic [3:0] dps,
                                           input int slot, input bit blank_en);
    int         d;
    logic [3:0] an;
    logic [6:0] sg;
    d = (value >> (4 * slot)) % 16;
    if (blank_en && slot > 0 && (value >> (4 * slot)) == 0)
      return {4'b1111, 7'b1111111, 1'b1};
    an       = 4'b1111;
    an[slot] = 1'b0;
    sg       = (d > 9) ? 7'b0111111 : seg_tab[d];
    return {an, sg, ~dps[slot]};
  endfunction

  int          k       = 0;
  int          m_slot  = 0;
  int          m_shad  = 0;
  logic [3:0]  m_dps   = 4'h0;
  bit          m_bad   = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge sclk or posedge rst) begin
    logic [11:0] va, vb;
    if (rst) begin
      k      = 0;
      m_shad = 0;
      m_dps  = 4'h0;
      m_bad  = 1'b0;
      exp_q.delete();
    end else begin
      k++;
      m_slot = ((k - 1) / RD) % 4;
      va = ref_view(m_shad, m_dps, m_slot, 1'b1);
      vb = ~ref_view(m_shad, m_dps, m_slot, 1'b0);
      if (k % FRAME == 0) begin
        m_shad = int'(bcd);
        m_dps  = dpe;
        for (int i = 0; i < 4; i++) if (((m_shad >> (4 * i)) % 16) > 9) m_bad = 1'b1;
      end
      exp_q.push_back({va, m_bad, vb, m_bad});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge sclk) begin
    logic [W-1:0] e, g;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {if_a.an, if_a.seg, if_a.dp, if_a.bad_digit, if_b.an, if_b.seg, if_b.dp, if_b.bad_digit};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scan t=%0t value=%h: got a{an=%b seg=%b dp=%b bad=%b} b{an=%b seg=%b dp=%b bad=%b} expected a{an=%b seg=%b dp=%b bad=%b} b{an=%b seg=%b dp=%b bad=%b}",
                 $time, bcd, g[25:22], g[21:15], g[14], g[13], g[12:9], g[8:2], g[1], g[0],
                 e[25:22], e[21:15], e[14], e[13], e[12:9], e[8:2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic set_in(input logic [15:0] v, input logic [3:0] d);
    @(negedge sclk);
    bcd = v;
    dpe = d;
  endtask

  task automatic check_reset(input string name);
    logic [12:0] ga, gb;
    ga = {if_a.an, if_a.seg, if_a.dp, if_a.bad_digit};
    gb = {if_b.an, if_b.seg, if_b.dp, if_b.bad_digit};
    checks++;
    if (ga !== 13'b1111_1111111_1_0 || gb !== 13'b0000_0000000_0_0) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b expected a=%b b=%b", name, ga, gb,
               13'b1111_1111111_1_0, 13'b0000_0000000_0_0);
    end
  endtask

  task automatic mid_reset(input string name);
    @(posedge sclk);
    #2 rst = 1'b1;
    #1 check_reset(name);
    @(negedge sclk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idx(input int want);
    int i;
    for (i = 0; i < 8 * FRAME; i++) begin
      @(negedge sclk);
      if ((k / RD) % 4 == want) break;
    end
    if (i == 8 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL wait_idx: digit slot %0d not seen within %0d cycles", want, 8 * FRAME);
    end
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    run(3);
    check_reset("reset_initial");
    #1 rst = 1'b0;
    run(2 * FRAME);

    set_in(16'h1234, 4'h0);
    run(3 * FRAME);

    wait_idx(1);
    bcd = 16'h5678;
    run(2 * FRAME);

    set_in(16'h0042, 4'h0);
    run(2 * FRAME);
    set_in(16'h00A5, 4'h0);
    run(2 * FRAME);
    set_in(16'h0005, 4'h0);
    run(2 * FRAME);
    mid_reset("reset_mid_frame");
    run(2 * FRAME);

    set_in(16'h0123, 4'b0100);
    run(2 * FRAME);
    set_in(16'h0003, 4'b0100);
    run(2 * FRAME);
    set_in(16'h9999, 4'hF);
    run(2 * FRAME);
    set_in(16'h0000, 4'hF);
    run(2 * FRAME);

    for (int i = 0; i < 40; i++) begin
      set_in(rand_value(), 4'($urandom_range(0, 15)));
      run($urandom_range(1, 3 * FRAME));
      if (i == 20) mid_reset("reset_random");
    end
    run(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
